// File: rtl/stream_demux3_if.sv
// Handshake bundle for stream_demux3: one input stream, three output channels, busy.
// slave is the demux side, master is the producer/consumer side.
interface stream_demux3_if #(
    parameter int WIDTH = 8
);
    logic             cs;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_sel;
    logic [WIDTH-1:0] in_data;
    logic             alpha_valid;
    logic             alpha_ready;
    logic [WIDTH-1:0] alpha_data;
    logic             beta_valid;
    logic             beta_ready;
    logic [WIDTH-1:0] beta_data;
    logic             gamma_valid;
    logic             gamma_ready;
    logic [WIDTH-1:0] gamma_data;
    logic             busy;

    modport slave (
        input  cs, in_valid, in_sel, in_data,
        input  alpha_ready, beta_ready, gamma_ready,
        output in_ready,
        output alpha_valid, alpha_data,
        output beta_valid, beta_data,
        output gamma_valid, gamma_data,
        output busy
    );

    modport master (
        output cs, in_valid, in_sel, in_data,
        output alpha_ready, beta_ready, gamma_ready,
        input  in_ready,
        input  alpha_valid, alpha_data,
        input  beta_valid, beta_data,
        input  gamma_valid, gamma_data,
        input  busy
    );
endinterface

// File: rtl/stream_demux3.sv
// One-to-three stream demux with a single holding register per channel.
// Optional STREAM_DEMUX3_DROP_CNT_EN adds a saturating count of discarded (sel 3) words.
module stream_demux3 #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              nreset,
    stream_demux3_if.slave    s
`ifdef STREAM_DEMUX3_DROP_CNT_EN
    ,
    output logic [7:0]        drop_cnt
`endif
);

    logic [2:0]       full_q, full_d;
    logic [WIDTH-1:0] data_q [3];
    logic [WIDTH-1:0] data_d [3];
    logic [2:0]       out_rdy;
    logic [3:0]       full_ext;
    logic [3:0]       rdy_ext;
    logic             in_ready_int;
    logic             in_fire;

    assign out_rdy  = {s.gamma_ready, s.beta_ready, s.alpha_ready};
    // Slot 3 (discard) always looks empty and ready so it never stalls.
    assign full_ext = {1'b0, full_q};
    assign rdy_ext  = {1'b1, out_rdy};

    assign in_ready_int = s.cs & ((s.in_sel == 2'd3) | ~full_ext[s.in_sel] | rdy_ext[s.in_sel]);
    assign in_fire      = s.in_valid & in_ready_int;
    assign s.in_ready   = in_ready_int;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        for (int i = 0; i < 3; i++) begin
            if (full_q[i] && out_rdy[i]) begin
                full_d[i] = 1'b0;
            end
            if (in_fire && (s.in_sel == 2'(i))) begin
                full_d[i] = 1'b1;
                data_d[i] = s.in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            full_q <= '0;
            for (int i = 0; i < 3; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign s.alpha_valid = full_q[0];
    assign s.beta_valid  = full_q[1];
    assign s.gamma_valid = full_q[2];
    assign s.alpha_data  = data_q[0];
    assign s.beta_data   = data_q[1];
    assign s.gamma_data  = data_q[2];
    assign s.busy        = |full_q;

`ifdef STREAM_DEMUX3_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (in_fire && (s.in_sel == 2'd3) && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_stream_demux3.sv
// Directed bench for stream_demux3: vector table plus reset and discard sequences.
module tb_stream_demux3;

    logic clk;
    logic nreset;
    int   checks;
    int   errors;

    stream_demux3_if #(.WIDTH(8)) bus ();

`ifdef STREAM_DEMUX3_DROP_CNT_EN
    logic [7:0] drop_cnt;
    stream_demux3 #(.WIDTH(8)) dut (
        .clk      (clk),
        .nreset   (nreset),
        .s        (bus),
        .drop_cnt (drop_cnt)
    );
`else
    stream_demux3 #(.WIDTH(8)) dut (
        .clk    (clk),
        .nreset (nreset),
        .s      (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       cs;
        logic       vld;
        logic [1:0] sel;
        logic [7:0] d;
        logic [2:0] rdy;      // {gamma, beta, alpha}
        logic       exp_rdy;  // in_ready before the edge
        logic [2:0] exp_v;    // valids after the edge
        logic [7:0] ea;
        logic [7:0] eb;
        logic [7:0] eg;
        logic       exp_busy;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cs, input logic vld, input logic [1:0] sel,
                         input logic [7:0] d, input logic [2:0] rdy);
        bus.cs          = cs;
        bus.in_valid    = vld;
        bus.in_sel      = sel;
        bus.in_data     = d;
        bus.alpha_ready = rdy[0];
        bus.beta_ready  = rdy[1];
        bus.gamma_ready = rdy[2];
    endtask

    function automatic logic [2:0] valids();
        return {bus.gamma_valid, bus.beta_valid, bus.alpha_valid};
    endfunction

    initial begin
        checks = 0;
        errors = 0;

        //           cs  vld sel  d      rdy     erdy ev      ea     eb     eg     busy
        vecs[0]  = '{1'b1, 1'b1, 2'd0, 8'h11, 3'b111, 1'b1, 3'b001, 8'h11, 8'h00, 8'h00, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 2'd1, 8'h22, 3'b111, 1'b1, 3'b010, 8'h11, 8'h22, 8'h00, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 2'd2, 8'h33, 3'b111, 1'b1, 3'b100, 8'h11, 8'h22, 8'h33, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 2'd0, 8'hA5, 3'b000, 1'b1, 3'b101, 8'hA5, 8'h22, 8'h33, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 2'd0, 8'h5A, 3'b000, 1'b0, 3'b101, 8'hA5, 8'h22, 8'h33, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 2'd2, 8'h77, 3'b100, 1'b1, 3'b101, 8'hA5, 8'h22, 8'h77, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 2'd0, 8'h5A, 3'b001, 1'b1, 3'b101, 8'h5A, 8'h22, 8'h77, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 2'd3, 8'hFF, 3'b000, 1'b1, 3'b101, 8'h5A, 8'h22, 8'h77, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 2'd1, 8'hEE, 3'b101, 1'b0, 3'b000, 8'h5A, 8'h22, 8'h77, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 2'd1, 8'hEE, 3'b000, 1'b0, 3'b000, 8'h5A, 8'h22, 8'h77, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 2'd1, 8'hC3, 3'b000, 1'b1, 3'b000, 8'h5A, 8'h22, 8'h77, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 2'd1, 8'h3C, 3'b000, 1'b1, 3'b010, 8'h5A, 8'h3C, 8'h77, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 2'd1, 8'h99, 3'b010, 1'b0, 3'b000, 8'h5A, 8'h3C, 8'h77, 1'b0};

        // Reset state, in_ready tracks cs while in reset
        nreset = 1'b0;
        drive(1'b1, 1'b1, 2'd0, 8'h00, 3'b000);
        #3;
        check("reset in_ready cs1", {31'd0, bus.in_ready}, 32'd1);
        check("reset valids", {29'd0, valids()}, 32'd0);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset alpha_data", {24'd0, bus.alpha_data}, 32'd0);
        bus.cs = 1'b0;
        #1;
        check("reset in_ready cs0", {31'd0, bus.in_ready}, 32'd0);
`ifdef STREAM_DEMUX3_DROP_CNT_EN
        check("reset drop_cnt", {24'd0, drop_cnt}, 32'd0);
`endif
        @(negedge clk);
        nreset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].cs, vecs[i].vld, vecs[i].sel, vecs[i].d, vecs[i].rdy);
            #1;
            check($sformatf("v%0d in_ready", i), {31'd0, bus.in_ready}, {31'd0, vecs[i].exp_rdy});
            @(posedge clk);
            #1;
            check($sformatf("v%0d valids", i), {29'd0, valids()}, {29'd0, vecs[i].exp_v});
            check($sformatf("v%0d alpha_data", i), {24'd0, bus.alpha_data}, {24'd0, vecs[i].ea});
            check($sformatf("v%0d beta_data", i), {24'd0, bus.beta_data}, {24'd0, vecs[i].eb});
            check($sformatf("v%0d gamma_data", i), {24'd0, bus.gamma_data}, {24'd0, vecs[i].eg});
            check($sformatf("v%0d busy", i), {31'd0, bus.busy}, {31'd0, vecs[i].exp_busy});
        end

        // Fill all three channels, then reset mid-operation
        drive(1'b1, 1'b1, 2'd0, 8'h01, 3'b000);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 2'd1, 8'h02, 3'b000);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 2'd2, 8'h03, 3'b000);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("full valids", {29'd0, valids()}, 32'd7);
        check("full gamma_data", {24'd0, bus.gamma_data}, 32'h03);
        check("full busy", {31'd0, bus.busy}, 32'd1);
        #2;
        nreset = 1'b0;
        #1;
        check("midreset valids", {29'd0, valids()}, 32'd0);
        check("midreset busy", {31'd0, bus.busy}, 32'd0);
        check("midreset beta_data", {24'd0, bus.beta_data}, 32'd0);
        @(negedge clk);
        nreset = 1'b1;
        drive(1'b1, 1'b1, 2'd1, 8'h44, 3'b000);
        #1;
        check("post reset in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        check("post reset valids", {29'd0, valids()}, 32'd2);
        check("post reset beta_data", {24'd0, bus.beta_data}, 32'h44);
        drive(1'b1, 1'b0, 2'd0, 8'h00, 3'b111);
        @(posedge clk); #1;
        check("post reset drained", {29'd0, valids()}, 32'd0);

        // Discard stream: nothing becomes valid, counter saturates
        drive(1'b1, 1'b1, 2'd3, 8'hC0, 3'b111);
        for (int i = 0; i < 300; i++) begin
            bus.in_data = 8'(i);
            @(posedge clk); #1;
            check($sformatf("discard %0d valids", i), {29'd0, valids()}, 32'd0);
`ifdef STREAM_DEMUX3_DROP_CNT_EN
            check($sformatf("discard %0d drop_cnt", i), {24'd0, drop_cnt},
                  (i + 1 > 255) ? 32'd255 : 32'(i + 1));
`endif
        end
        check("discard busy", {31'd0, bus.busy}, 32'd0);
        bus.in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_demux3.md
STREAM_DEMUX3 -- requirements
Module: stream_demux3

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data width of the input and of each output channel.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port nreset, input, 1, the reset; asynchronous, active-low.
REQ-004 The block SHALL have port cs, input, 1, chip select; low blocks new input transfers.
REQ-005 The block SHALL have port in_valid, input, 1, the input word is valid.
REQ-006 The block SHALL have port in_ready, output, 1, the block accepts the input word this cycle.
REQ-007 The block SHALL have port in_sel, input, 2, the destination: 0=alpha, 1=beta, 2=gamma, 3=discard.
REQ-008 The block SHALL have port in_data, input, WIDTH, the input word.
REQ-009 The block SHALL have ports alpha_valid, beta_valid, gamma_valid, output, 1 each, the output word is valid.
REQ-010 The block SHALL have ports alpha_ready, beta_ready, gamma_ready, input, 1 each, the consumer accepts the word.
REQ-011 The block SHALL have ports alpha_data, beta_data, gamma_data, output, WIDTH each, the output words.
REQ-012 The block SHALL have port busy, output, 1, high while any output register holds a word.

Function
REQ-013 Each output channel SHALL own one holding register plus a full flag; X_valid SHALL equal the full flag, and X_data SHALL equal the register contents.
REQ-014 An input transfer SHALL occur when in_valid and in_ready are both high at a rising edge; an output transfer SHALL occur when X_valid and X_ready are both high.
REQ-015 in_ready SHALL be combinational: cs AND (in_sel==3 OR the selected register is empty OR its X_ready is high).
REQ-016 in_ready SHALL NOT depend on in_valid.
REQ-017 On an input transfer with in_sel 0..2, the selected register SHALL load in_data and be full from the next cycle; the latency is one cycle, in to X_valid.
REQ-018 On an output transfer with no load in the same cycle, the full flag SHALL clear at that edge.
REQ-019 When an input and an output transfer hit the same channel in the same cycle, the register SHALL load the new word, stay full, and drop no word.
REQ-020 Holding registers of unselected channels SHALL be unaffected by input transfers.
REQ-021 A full register SHALL keep its data and valid stable until it is accepted; it SHALL NOT be overwritten.
REQ-022 Channels SHALL drain independently; a stalled channel SHALL NOT block transfers to the other channels.
REQ-023 An input transfer with in_sel==3 SHALL be accepted and discarded; no output changes.
REQ-024 With cs low, in_ready SHALL be 0 and words already held SHALL still drain normally; deasserting cs mid-stream SHALL lose no held word.
REQ-025 busy SHALL equal the OR of the three full flags, taken from registers.

Reset
REQ-026 While nreset is low, all full flags SHALL be 0 and all data registers SHALL be 0, asynchronously; X_valid and busy therefore read 0.
REQ-027 Reset mid-operation SHALL discard held words; the first transfer SHALL be accepted on the first rising edge after nreset deasserts.
REQ-028 in_ready SHALL follow REQ-015 during reset; because all registers are empty, it equals cs.

Configuration
REQ-029 With macro STREAM_DEMUX3_DROP_CNT_EN defined, the block SHALL have an extra output drop_cnt, 8 bits, reset 0, incremented on each in_sel==3 transfer and saturating at 255.
REQ-030 Without STREAM_DEMUX3_DROP_CNT_EN, the drop_cnt port and its counter SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-031 Scenario: cs=1, all X_ready=1; send 0x11 sel0, 0x22 sel1, 0x33 sel2 on consecutive cycles -> alpha 0x11, beta 0x22, gamma 0x33 each valid one cycle after acceptance, in_ready stays 1.
REQ-032 Scenario: alpha_ready=0; send 0xA5 sel0, then 0x5A sel0 -> second word stalls (in_ready=0), alpha_data holds 0xA5; raise alpha_ready -> 0xA5 then 0x5A delivered in order.
REQ-033 Scenario: alpha full and stalled; send 0x77 sel2 -> accepted, gamma_data=0x77 the next cycle, alpha unchanged.
REQ-034 Scenario: cs=0 with in_valid=1 and beta full -> in_ready=0 and no load occurs, while beta drains when beta_ready=1 and busy falls to 0.
REQ-035 Scenario: 300 transfers with sel3 (macro defined) -> no output becomes valid and drop_cnt saturates at 255.
REQ-036 Scenario: assert nreset low while all three channels are full -> all valids and busy drop immediately, and the next word after release is delivered with 1-cycle latency.
